tiny_proc_run_ctrl: RTL
=======================

// Module: tiny_proc_run_ctrl
// PURPOSE
// Run/halt/single-step controller and program-memory owner for the 5-bit tiny processor.
// Holds the 32x9 program RAM that replaces the hard-coded ROM. Serves the core's fetch port.
// Accepts host load/run/step/halt commands and gates core progress via core_en.
// Supports one address breakpoint and counts retired instructions.
// PARAMETERS
// AW     5   program address width (PC width); memory depth = 2**AW
// DW     9   instruction word width {INST[3:0], IMM[4:0]}
// CNT_W  8   retire counter width
// PORTS
// clock        in   1      single system clock, all logic on rising edge
// reset_p      in   1      synchronous reset, active-high
// cmd_valid    in   1      host command valid
// cmd_ready    out  1      host command accepted when cmd_valid&cmd_ready
// cmd_op       in   2      00 RUN, 01 HALT, 10 STEP, 11 LOAD
// cmd_addr     in   AW     LOAD address
// cmd_data     in   DW     LOAD data
// fetch_req    in   1      core requests instruction at fetch_addr (core's ROM-read state)
// fetch_addr   in   AW     core PC
// fetch_valid  out  1      fetch_data valid (1 cycle after served request)
// fetch_data   out  DW     instruction word
// instr_done   in   1      core pulses in its write-back cycle (instruction retired)
// core_en      out  1      core advances its state machine only while 1
// bp_en        in   1      breakpoint enable
// bp_addr      in   AW     breakpoint address
// bp_hit       out  1      1-cycle pulse: breakpoint halted the core
// cmd_err      out  1      1-cycle pulse: accepted command was rejected/dropped
// halted       out  1      state==HALTED
// retire_cnt   out  CNT_W  retired instruction count, saturating
// BEHAVIOUR
// - Reset (sync): state=HALTED, all program RAM words=0, retire_cnt=0, bp_skip=0; outputs
//   cmd_ready=1, fetch_valid=0, fetch_data=0, core_en=0, bp_hit=0, cmd_err=0, halted=1.
// - States HALTED, RUNNING, DRAIN, LOADING. core_en = (RUNNING|DRAIN), decoded from registered state.
// - cmd_ready = (HALTED|RUNNING); 0 in DRAIN and LOADING.
// - HALTED: RUN->RUNNING; STEP->DRAIN; LOAD->LOADING (addr/data captured); HALT->no-op.
// - LOADING: one cycle; writes mem[addr]=data; ->HALTED. A LOAD write lands 2 cycles after accept.
// - RUNNING: RUN->no-op; HALT or STEP->DRAIN; LOAD->dropped, cmd_err=1, no write.
// - DRAIN: on instr_done->HALTED; core_en is 0 the following cycle, so exactly the in-flight
//   (or, from HALTED, exactly one) instruction retires.
// - RUNNING + accepted HALT/STEP + instr_done same cycle -> HALTED directly.
// - Fetch: while core_en=1, fetch_req in cycle N -> fetch_valid=1, fetch_data=mem[fetch_addr] in N+1.
//   fetch_req with core_en=0 is ignored (fetch_valid=0). fetch_data holds last value otherwise.
// - Breakpoint: RUNNING & fetch_req & bp_en & fetch_addr==bp_addr & !bp_skip -> not served;
//   next state HALTED, bp_hit=1 next cycle, bp_skip set. bp has priority over a same-cycle
//   accepted command, which is dropped with cmd_err=1.
// - bp_skip cleared on the first served fetch; lets RUN/STEP resume past the breakpoint once.
//   Breakpoint is not checked in DRAIN.
// - retire_cnt += 1 on instr_done while core_en=1; saturates at 2**CNT_W-1.
// - Reset mid-operation (any state, incl. LOADING) aborts with no write; RAM cleared.
// TESTING
// - Reset, LOAD addr 0..8 with LED program (0x101,0x102,...,0x141), read back via STEP fetches -> data match, cmd_err=0.
// - STEP from HALTED with core stub (5-cycle instr) -> core_en high until instr_done, low next cycle, retire_cnt=1, halted=1.
// - RUN then HALT mid-instruction -> cmd_ready=0 in DRAIN, HALTED after instr_done, no extra fetch served.
// - bp_en=1, bp_addr=4, RUN from PC 0 -> bp_hit one cycle after fetch_addr=4 request, halted=1, retire_cnt=4; RUN -> fetch 4 served.
// - LOAD while RUNNING -> cmd_err pulse, mem unchanged; HALT+instr_done same cycle -> HALTED next cycle.
// - 300 retirements in RUNNING -> retire_cnt=255; reset_p during LOADING -> RAM word still 0.

Source files
------------

// File: rtl/tiny_proc_run_ctrl.sv
// Run/halt/single-step controller for the 5-bit tiny processor.
// It owns the program RAM, serves core fetches, handles one breakpoint and counts retired instructions.
module tiny_proc_run_ctrl #(
    parameter int AW    = 5,
    parameter int DW    = 9,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_p,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [DW-1:0]    cmd_data,
    input  logic             fetch_req,
    input  logic [AW-1:0]    fetch_addr,
    output logic             fetch_valid,
    output logic [DW-1:0]    fetch_data,
    input  logic             instr_done,
    output logic             core_en,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    output logic             bp_hit,
    output logic             cmd_err,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'b00,
        ST_RUNNING = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_LOADING = 2'b11
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;
    localparam int         DEPTH   = 2 ** AW;

    state_t            state_q, state_d;
    logic [AW-1:0]     ld_addr_q, ld_addr_d;
    logic [DW-1:0]     ld_data_q, ld_data_d;
    logic              bp_skip_q, bp_skip_d;
    logic              bp_hit_q, bp_hit_d;
    logic              cmd_err_q, cmd_err_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DW-1:0]     fetch_data_q, fetch_data_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic              mem_we;
    logic              cmd_acc;
    logic              bp_trig;
    logic              fetch_serve;

    assign cmd_ready   = (state_q == ST_HALTED) || (state_q == ST_RUNNING);
    assign core_en     = (state_q == ST_RUNNING) || (state_q == ST_DRAIN);
    assign halted      = (state_q == ST_HALTED);
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign bp_hit      = bp_hit_q;
    assign cmd_err     = cmd_err_q;
    assign retire_cnt  = retire_q;

    assign cmd_acc     = cmd_valid && cmd_ready;
    assign bp_trig     = (state_q == ST_RUNNING) && fetch_req && bp_en &&
                         (fetch_addr == bp_addr) && !bp_skip_q;
    assign fetch_serve = core_en && fetch_req && !bp_trig;

    // Next-state, fetch service, breakpoint and retire-counter logic.
    always_comb begin
        state_d       = state_q;
        ld_addr_d     = ld_addr_q;
        ld_data_d     = ld_data_q;
        bp_skip_d     = bp_skip_q;
        bp_hit_d      = 1'b0;
        cmd_err_d     = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        retire_d      = retire_q;
        mem_we        = 1'b0;

        if (fetch_serve) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = mem_q[fetch_addr];
            bp_skip_d     = 1'b0;
        end else begin
            fetch_valid_d = 1'b0;
        end

        if (instr_done && core_en && (retire_q != {CNT_W{1'b1}})) begin
            retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_d = retire_q;
        end

        case (state_q)
            ST_HALTED: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN:  state_d = ST_RUNNING;
                        OP_STEP: state_d = ST_DRAIN;
                        OP_LOAD: begin
                            state_d   = ST_LOADING;
                            ld_addr_d = cmd_addr;
                            ld_data_d = cmd_data;
                        end
                        default: state_d = ST_HALTED;
                    endcase
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RUNNING: begin
                // A breakpoint wins over any command arriving in the same cycle.
                if (bp_trig) begin
                    state_d   = ST_HALTED;
                    bp_hit_d  = 1'b1;
                    bp_skip_d = 1'b1;
                    cmd_err_d = cmd_acc;
                end else if (cmd_acc) begin
                    case (cmd_op)
                        OP_HALT, OP_STEP: state_d = instr_done ? ST_HALTED : ST_DRAIN;
                        OP_LOAD: cmd_err_d = 1'b1;
                        default: state_d = ST_RUNNING;
                    endcase
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_DRAIN: begin
                if (instr_done) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_LOADING: begin
                mem_we  = 1'b1;
                state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset_p) begin
            state_q       <= ST_HALTED;
            ld_addr_q     <= {AW{1'b0}};
            ld_data_q     <= {DW{1'b0}};
            bp_skip_q     <= 1'b0;
            bp_hit_q      <= 1'b0;
            cmd_err_q     <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= {DW{1'b0}};
            retire_q      <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            ld_addr_q     <= ld_addr_d;
            ld_data_q     <= ld_data_d;
            bp_skip_q     <= bp_skip_d;
            bp_hit_q      <= bp_hit_d;
            cmd_err_q     <= cmd_err_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            retire_q      <= retire_d;
        end
    end

    // Program RAM; reset clears every word, so a reset during LOADING drops the write.
    always_ff @(posedge clock) begin
        if (reset_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (mem_we) begin
            mem_q[ld_addr_q] <= ld_data_q;
        end
    end

endmodule
